// File: rtl/branch_resolve_pkg.sv
// Shared types and defaults for the branch resolution block.
package branch_pkg;

  // Branch class presented by decode
  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_B    = 2'd1,
    BR_COND = 2'd2,
    BR_CBZ  = 2'd3
  } br_kind_t;

  // ARM condition codes, encoded as in the instruction word
  typedef enum logic [3:0] {
    EQ = 4'd0,  NE = 4'd1,  HS = 4'd2,  LO = 4'd3,
    MI = 4'd4,  PL = 4'd5,  VS = 4'd6,  VC = 4'd7,
    HI = 4'd8,  LS = 4'd9,  GE = 4'd10, LT = 4'd11,
    GT = 4'd12, LE = 4'd13, AL = 4'd14, NV = 4'd15
  } cond_t;

  // Resolver sequencing state
  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Default number of wrong-path squash cycles after a taken branch
  localparam int FLUSH_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/branch_resolve_if.sv
// Execute-side bus into the branch resolver and its redirect outputs to fetch.
interface branch_resolve_if
  import branch_pkg::*;
#(
  parameter int ADDR_W = 64
);
  logic              instr_valid;
  br_kind_t          br_kind;
  logic [3:0]        cond;
  logic [ADDR_W-1:0] pc;
  logic [25:0]       imm26;
  logic [18:0]       imm19;
  logic [ADDR_W-1:0] cbz_val;
  logic              z_flag;
  logic              o_flag;
  logic              c_flag;
  logic              n_flag;
  logic              flags_pending;
  logic              stall_o;
  logic              taken_o;
  logic [ADDR_W-1:0] target_o;
  logic              flush_o;

  // Execute stage / testbench side
  modport master (
    output instr_valid, br_kind, cond, pc, imm26, imm19, cbz_val,
    output z_flag, o_flag, c_flag, n_flag, flags_pending,
    input  stall_o, taken_o, target_o, flush_o
  );

  // Resolver side
  modport slave (
    input  instr_valid, br_kind, cond, pc, imm26, imm19, cbz_val,
    input  z_flag, o_flag, c_flag, n_flag, flags_pending,
    output stall_o, taken_o, target_o, flush_o
  );
endinterface

// File: rtl/branch_resolve_cond_eval.sv
// Combinational ARM condition-code evaluator over the Z/V/C/N flags.
module cond_eval
  import branch_pkg::*;
(
  input  cond_t cond_i,
  input  logic  z_i,
  input  logic  o_i,
  input  logic  c_i,
  input  logic  n_i,
  output logic  pass_o
);

  logic base;

  // Codes come in complementary pairs: cond[3:1] picks the base test, cond[0] inverts it (AL/NV both pass)
  always_comb begin
    base = 1'b1;
    unique case (cond_i[3:1])
      3'd0: base = z_i;
      3'd1: base = c_i;
      3'd2: base = n_i;
      3'd3: base = o_i;
      3'd4: base = c_i & ~z_i;
      3'd5: base = (n_i == o_i);
      3'd6: base = ~z_i & (n_i == o_i);
      default: base = 1'b1;
    endcase
    pass_o = (cond_i[3:1] == 3'd7) ? 1'b1 : (base ^ cond_i[0]);
  end

endmodule

// File: rtl/branch_resolve.sv
// Resolves B / B.cond / CBZ, registers the redirect, and sequences the wrong-path flush.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
  input logic             clk,
  input logic             reset,
  branch_resolve_if.slave bus
);

  localparam int CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     taken_q, taken_d;
  logic [ADDR_W-1:0]        target_q, target_d;
  logic                     cond_pass;
  logic                     stall;
  logic                     decide;
  logic                     br_taken;
  logic signed [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0]        target_calc;

  cond_eval u_cond_eval (
    .cond_i (cond_t'(bus.cond)),
    .z_i    (bus.z_flag),
    .o_i    (bus.o_flag),
    .c_i    (bus.c_flag),
    .n_i    (bus.n_flag),
    .pass_o (cond_pass)
  );

  // Word offset scaled to bytes and sign-extended; the add wraps modulo 2^ADDR_W
  always_comb begin
    if (bus.br_kind == BR_B) begin
      offset = ADDR_W'(signed'({bus.imm26, 2'b00}));
    end else begin
      offset = ADDR_W'(signed'({bus.imm19, 2'b00}));
    end
    target_calc = bus.pc + $unsigned(offset);
  end

  // State register and flush counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a taken branch arms the squash window, which counts down to IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (br_taken) begin
          state_d = FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: stall B.cond on unsettled flags, decide only in IDLE, flush while in FLUSH
  always_comb begin
    stall    = (state_q == IDLE) & bus.instr_valid & (bus.br_kind == BR_COND) & bus.flags_pending;
    decide   = (state_q == IDLE) & bus.instr_valid & ~stall;
    br_taken = 1'b0;
    if (decide) begin
      unique case (bus.br_kind)
        BR_B:    br_taken = 1'b1;
        BR_COND: br_taken = cond_pass;
        BR_CBZ:  br_taken = (bus.cbz_val == '0);
        default: br_taken = 1'b0;
      endcase
    end
    taken_d  = br_taken;
    target_d = br_taken ? target_calc : target_q;
  end

  // Registered redirect toward the PC mux; taken is a one-cycle pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken_q  <= 1'b0;
      target_q <= '0;
    end else begin
      taken_q  <= taken_d;
      target_q <= target_d;
    end
  end

  assign bus.stall_o  = stall;
  assign bus.taken_o  = taken_q;
  assign bus.target_o = target_q;
  assign bus.flush_o  = (state_q == FLUSH);

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;
  import branch_pkg::*;

  localparam int ADDR_W = 64;
  localparam int FC     = 2;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  // Behavioural reference: expected registered outputs and remaining squash cycles
  bit          m_taken;
  logic [63:0] m_target;
  int          m_flush;

  branch_resolve_if #(.ADDR_W(ADDR_W)) bif ();

  branch_resolve #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(FC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit cond_true(input int c, input bit z, input bit v, input bit cy, input bit n);
    case (c)
      0:  return z;
      1:  return !z;
      2:  return cy;
      3:  return !cy;
      4:  return n;
      5:  return !n;
      6:  return v;
      7:  return !v;
      8:  return cy && !z;
      9:  return !cy || z;
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit model_taken();
    if (!bif.instr_valid) return 1'b0;
    case (int'(bif.br_kind))
      1: return 1'b1;
      2: return bif.flags_pending ? 1'b0
                : cond_true(int'(bif.cond), bif.z_flag, bif.o_flag, bif.c_flag, bif.n_flag);
      3: return bif.cbz_val == 64'd0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] model_target();
    longint off;
    if (int'(bif.br_kind) == 1) off = longint'($signed(bif.imm26));
    else off = longint'($signed(bif.imm19));
    return bif.pc + 64'(off * 4);
  endfunction

  // Reference model advances on each clock edge; reset clears it at once
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_taken  <= 1'b0;
      m_target <= 64'd0;
      m_flush  <= 0;
    end else if (m_flush > 0) begin
      m_flush <= m_flush - 1;
      m_taken <= 1'b0;
    end else if (model_taken()) begin
      m_taken  <= 1'b1;
      m_target <= model_target();
      m_flush  <= FC;
    end else begin
      m_taken <= 1'b0;
    end
  end

  // Compare DUT against the model mid-cycle, every cycle
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_taken", 64'(bif.taken_o), 64'd0);
      chk("rst_flush", 64'(bif.flush_o), 64'd0);
      chk("rst_target", bif.target_o, 64'd0);
    end else begin
      chk("stall", 64'(bif.stall_o),
          64'((m_flush == 0) && bif.instr_valid && int'(bif.br_kind) == 2 && bif.flags_pending));
      chk("taken", 64'(bif.taken_o), 64'(m_taken));
      chk("flush", 64'(bif.flush_o), 64'(m_flush > 0));
      if (m_taken) chk("target", bif.target_o, m_target);
    end
  end

  task automatic drive(input bit v, input int k, input int c, input logic [63:0] p,
                       input logic [25:0] i26, input logic [18:0] i19, input logic [63:0] cz,
                       input logic [3:0] fl, input bit pend);
    bif.instr_valid   = v;
    bif.br_kind       = br_kind_t'(k[1:0]);
    bif.cond          = c[3:0];
    bif.pc            = p;
    bif.imm26         = i26;
    bif.imm19         = i19;
    bif.cbz_val       = cz;
    bif.z_flag        = fl[3];
    bif.n_flag        = fl[2];
    bif.c_flag        = fl[1];
    bif.o_flag        = fl[0];
    bif.flags_pending = pend;
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 64'd0, 26'd0, 19'd0, 64'd1, 4'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_taken", 64'(bif.taken_o), 64'd0);
    chk("reset_target", bif.target_o, 64'd0);
    chk("reset_flush", 64'(bif.flush_o), 64'd0);
    chk("reset_stall", 64'(bif.stall_o), 64'd0);
    tick();
    reset = 1'b0;

    // B backwards by one word from 0x1000
    tick();
    drive(1'b1, 1, 0, 64'h1000, 26'h3FFFFFF, 19'd0, 64'd1, 4'd0, 1'b0);
    tick();
    idle();
    @(negedge clk);
    chk("b_taken", 64'(bif.taken_o), 64'd1);
    chk("b_target", bif.target_o, 64'hFFC);
    chk("b_flush1", 64'(bif.flush_o), 64'd1);
    @(negedge clk);
    chk("b_pulse_end", 64'(bif.taken_o), 64'd0);
    chk("b_flush2", 64'(bif.flush_o), 64'd1);
    @(negedge clk);
    chk("b_flush_done", 64'(bif.flush_o), 64'd0);

    // B with imm26 = -4 words
    tick();
    drive(1'b1, 1, 0, 64'h1000, 26'h3FFFFFC, 19'd0, 64'd1, 4'd0, 1'b0);
    tick();
    idle();
    @(negedge clk);
    chk("b4_target", bif.target_o, 64'hFF0);
    repeat (3) tick();

    // GT with Z=0, N=1, V=1 passes
    drive(1'b1, 2, 12, 64'h0, 26'd0, 19'd1, 64'd1, 4'b0101, 1'b0);
    tick();
    idle();
    @(negedge clk);
    chk("gt_taken", 64'(bif.taken_o), 64'd1);
    repeat (3) tick();

    // Full condition x flags sweep
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        drive(1'b1, 2, c, {32'd0, $urandom}, 26'd0, 19'($urandom), 64'd1, f[3:0], 1'b0);
        tick();
        idle();
        repeat (3) tick();
      end
    end

    // CBZ taken and not taken
    drive(1'b1, 3, 0, 64'h2000, 26'd0, 19'd3, 64'd0, 4'd0, 1'b0);
    tick();
    idle();
    @(negedge clk);
    chk("cbz0_taken", 64'(bif.taken_o), 64'd1);
    chk("cbz0_target", bif.target_o, 64'h200C);
    repeat (3) tick();
    drive(1'b1, 3, 0, 64'h2000, 26'd0, 19'd3, 64'd1, 4'd0, 1'b0);
    tick();
    idle();
    @(negedge clk);
    chk("cbz1_taken", 64'(bif.taken_o), 64'd0);
    chk("cbz1_flush", 64'(bif.flush_o), 64'd0);
    repeat (2) tick();

    // B.cond EQ held by pending flags, Z=1
    drive(1'b1, 2, 0, 64'h3000, 26'd0, 19'd8, 64'd1, 4'b1000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("pend_stall", 64'(bif.stall_o), 64'd1);
      tick();
    end
    drive(1'b1, 2, 0, 64'h3000, 26'd0, 19'd8, 64'd1, 4'b1000, 1'b0);
    @(negedge clk);
    chk("pend_release", 64'(bif.stall_o), 64'd0);
    tick();
    idle();
    @(negedge clk);
    chk("pend_taken", 64'(bif.taken_o), 64'd1);
    chk("pend_target", bif.target_o, 64'h3020);
    repeat (3) tick();

    // Second B during flush is dropped
    drive(1'b1, 1, 0, 64'h4000, 26'd4, 19'd0, 64'd1, 4'd0, 1'b0);
    tick();
    drive(1'b1, 1, 0, 64'h5000, 26'd8, 19'd0, 64'd1, 4'd0, 1'b0);
    tick();
    idle();
    @(negedge clk);
    chk("b2b_dropped", 64'(bif.taken_o), 64'd0);
    repeat (3) tick();

    // Reset mid-flush
    drive(1'b1, 1, 0, 64'h6000, 26'd2, 19'd0, 64'd1, 4'd0, 1'b0);
    tick();
    idle();
    @(negedge clk);
    chk("mid_flush_pre", 64'(bif.flush_o), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_flush", 64'(bif.flush_o), 64'd0);
    chk("mid_rst_taken", 64'(bif.taken_o), 64'd0);
    tick();
    reset = 1'b0;
    tick();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
            {$urandom, $urandom}, 26'($urandom), 19'($urandom),
            ($urandom_range(0, 1) == 0) ? 64'd0 : {$urandom, $urandom},
            4'($urandom), $urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;
    idle();
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
